skew_stream_buffer: RTL

Parametrised, stall-aware successor to the triangular skew buffer. It turns one operand vector per cycle into the diagonal wavefront a systolic array needs (SKEW mode), or realigns a diagonal result wavefront back into a vector (DESKEW mode). It carries per-lane valid bits and a tile-end marker alongside the data. After the last vector of a tile it drains on its own, injecting zero bubbles and back-pressuring upstream until the tail has left.

---
 rtl/skew_pkg.sv | 28 ++
 rtl/skew_delay_line.sv | 52 +++++
 rtl/skew_stream_buffer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/skew_pkg.sv
// Shared types for the skew/deskew stream buffer.
// Mode and FSM enums plus the per-lane delay helper.
package skew_pkg;

   typedef enum logic {
      SKEW_MODE_SKEW,
      SKEW_MODE_DESKEW
   } skew_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } skew_state_e;

   // Total register depth of one lane, including the optional output stage.
   function automatic int lane_delay(
      input int         lane,
      input int         size,
      input skew_mode_e mode,
      input int         out_reg
   );
      int d;
      d = (mode == SKEW_MODE_SKEW) ? lane : (size - 1 - lane);
      return d + out_reg;
   endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One lane of the skew buffer: a data+valid shift line of DEPTH entries.
// Ports: clk_i/rst_i, en_i advance, data_i/valid_i in, data_o/valid_o out,
// busy_o high while any stored valid bit is in flight.
module skew_delay_line #(
   parameter int DEPTH      = 1,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic                  busy_o
);

   generate
      if (DEPTH == 0) begin : g_pass
         // Zero-delay lane: no storage, inputs pass straight through.
         logic pass_unused;
         assign pass_unused = ^{clk_i, rst_i, en_i};
         assign data_o  = data_i;
         assign valid_o = valid_i;
         assign busy_o  = 1'b0;
      end else begin : g_shift
         logic [DATA_WIDTH-1:0] data_q [DEPTH];
         logic [DEPTH-1:0]      valid_q;

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               for (int i = 0; i < DEPTH; i++) begin
                  data_q[i] <= '0;
               end
               valid_q <= '0;
            end else if (en_i) begin
               data_q[0]  <= data_i;
               valid_q[0] <= valid_i;
               for (int i = 1; i < DEPTH; i++) begin
                  data_q[i]  <= data_q[i-1];
                  valid_q[i] <= valid_q[i-1];
               end
            end
         end

         assign data_o  = data_q[DEPTH-1];
         assign valid_o = valid_q[DEPTH-1];
         assign busy_o  = |valid_q;
      end
   endgenerate

endmodule

// File: rtl/skew_stream_buffer.sv
// Stall-aware skew/deskew buffer with per-lane valid, tile-end marker and
// self-draining tail. Ports: clk, rst, enable, in_valid/in_last/in_ready,
// data_in, data_out, out_valid, out_last, busy.
module skew_stream_buffer
   import skew_pkg::*;
#(
   parameter int         ARRAY_SIZE = 8,
   parameter int         DATA_WIDTH = 8,
   parameter skew_mode_e MODE       = SKEW_MODE_SKEW,
   parameter int         OUT_REG    = 0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 enable,
   input  logic                                 in_valid,
   input  logic                                 in_last,
   output logic                                 in_ready,
   input  logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] data_in,
   output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] data_out,
   output logic [ARRAY_SIZE-1:0]                out_valid,
   output logic                                 out_last,
   output logic                                 busy
);

   localparam int MAXD      = ARRAY_SIZE - 1;
   localparam int DRAIN_LEN = MAXD + OUT_REG;
   localparam int CW        = $clog2(ARRAY_SIZE + 1);

   skew_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic acc;
   logic last_busy;
   logic [ARRAY_SIZE-1:0] lane_busy;

   assign in_ready = enable & (state_q != DRAIN);
   // Gating with rst keeps zero-delay lanes quiet while reset is held.
   assign acc = in_valid & in_ready & ~rst;

   // Elements are two's complement; bubbles carry zero data.
   generate
      for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
         logic [DATA_WIDTH-1:0] lane_din;
         assign lane_din = acc ? data_in[i] : '0;

         skew_delay_line #(
            .DEPTH     (lane_delay(i, ARRAY_SIZE, MODE, OUT_REG)),
            .DATA_WIDTH(DATA_WIDTH)
         ) u_line (
            .clk_i  (clk),
            .rst_i  (rst),
            .en_i   (enable),
            .data_i (lane_din),
            .valid_i(acc),
            .data_o (data_out[i]),
            .valid_o(out_valid[i]),
            .busy_o (lane_busy[i])
         );
      end

      // Tile-end marker rides alongside the longest lane.
      if (DRAIN_LEN == 0) begin : g_last_pass
         assign out_last  = acc & in_last;
         assign last_busy = 1'b0;
      end else begin : g_last_chain
         logic [DRAIN_LEN-1:0] last_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               last_q <= '0;
            end else if (enable) begin
               last_q[0] <= acc & in_last;
               for (int i = 1; i < DRAIN_LEN; i++) begin
                  last_q[i] <= last_q[i-1];
               end
            end
         end

         assign out_last  = last_q[DRAIN_LEN-1];
         assign last_busy = |last_q;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (enable) begin
         unique case (state_q)
            IDLE, STREAM: begin
               if (acc) begin
                  if (!in_last) begin
                     state_d = STREAM;
                  end else if (DRAIN_LEN != 0) begin
                     state_d = DRAIN;
                     cnt_d   = CW'(DRAIN_LEN);
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            DRAIN: begin
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q != IDLE) | (|lane_busy) | last_busy;

endmodule
